// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// instr_fetch_unit : IF stage (PC, imem req/ready, skid buffer) and IF/ID reg.
// Optional macro FETCH_PERF_COUNT_EN adds fetch/bubble counter outputs.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              branch_taken_in,
    input  logic [ADDR_W-1:0] branch_target_in,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic              imem_ready_in,
    input  logic [31:0]       imem_data_in,
    output logic [31:0]       IR_out,
    output logic [ADDR_W-1:0] PC_out,
    output logic [ADDR_W-1:0] PC4_out,
    output logic              valid_out
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]       fetch_count_out,
    output logic [31:0]       bubble_count_out
`endif
);

    localparam logic [ADDR_W-1:0] c_pc_inc     = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(3);
    localparam logic [31:0]       c_nop        = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              load_valid;
    logic              load_bubble;
    logic              xfer;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        pc_out_d    = pc_out_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        load_valid  = 1'b0;
        load_bubble = 1'b0;
        xfer        = (state_q == ST_FETCH) && imem_ready_in;

        if (state_q != ST_BOOT && branch_taken_in) begin
            // Redirect wins over stall; any same-cycle response is dropped.
            pc_d        = branch_target_in & ~c_align_mask;
            ir_d        = c_nop;
            valid_d     = 1'b0;
            skid_data_d = '0;
            skid_pc_d   = '0;
            state_d     = ST_FETCH;
            load_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!stall_in) begin
                        if (xfer) begin
                            ir_d       = imem_data_in;
                            pc_out_d   = pc_q;
                            pc4_d      = pc_q + c_pc_inc;
                            valid_d    = 1'b1;
                            pc_d       = pc_q + c_pc_inc;
                            load_valid = 1'b1;
                        end else begin
                            ir_d        = c_nop;
                            valid_d     = 1'b0;
                            load_bubble = 1'b1;
                        end
                    end else if (xfer) begin
                        // Response accepted under stall is parked until release.
                        skid_data_d = imem_data_in;
                        skid_pc_d   = pc_q;
                        pc_d        = pc_q + c_pc_inc;
                        state_d     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!stall_in) begin
                        ir_d        = skid_data_q;
                        pc_out_d    = skid_pc_q;
                        pc4_d       = skid_pc_q + c_pc_inc;
                        valid_d     = 1'b1;
                        skid_data_d = '0;
                        skid_pc_d   = '0;
                        state_d     = ST_FETCH;
                        load_valid  = 1'b1;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            ir_q        <= c_nop;
            pc_out_q    <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pc_out_q    <= pc_out_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign imem_req_out  = (state_q == ST_FETCH);
    assign imem_addr_out = pc_q;
    assign IR_out        = ir_q;
    assign PC_out        = pc_out_q;
    assign PC4_out       = pc4_q;
    assign valid_out     = valid_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load_valid};
        bubble_cnt_d = bubble_cnt_q + {31'd0, load_bubble};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count_out  = fetch_cnt_q;
    assign bubble_count_out = bubble_cnt_q;
`else
    logic unused_counts;
    assign unused_counts = load_valid ^ load_bubble;
`endif

endmodule
`default_nettype wire
